// File: rtl/nco_core.sv
// Numerically controlled oscillator: phase accumulator feeding square, sawtooth
// and triangle shapers, with tuning updates deferred to period boundaries.
module nco_core #(
  parameter int ACC_W = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       wave,
  input  logic [ACC_W-1:0] frequency,
  input  logic [OUT_W-1:0] duty_cycle,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             sync
);

  // state | meaning
  // IDLE  | phase and outputs held at zero, active registers track the inputs
  // RUN   | accumulator stepping every clock, samples valid
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] f_act_q, f_act_d;
  logic [1:0]       w_act_q, w_act_d;
  logic [OUT_W-1:0] d_act_q, d_act_d;
  logic [OUT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;

  logic [ACC_W:0]   sum;
  logic [OUT_W-1:0] p;
  logic [OUT_W-1:0] tri_q;
  logic [OUT_W-1:0] wave_val;
  logic             load;

  assign sum   = {1'b0, phase_q} + {1'b0, f_act_q};
  assign p     = phase_q[ACC_W-1 -: OUT_W];
  assign tri_q = {p[OUT_W-2:0], 1'b0};

  always_comb begin
    wave_val = '0;
    case (w_act_q)
      2'b00:   wave_val = (p < d_act_q) ? '1 : '0;
      2'b01:   wave_val = p;
      2'b10:   wave_val = p[OUT_W-1] ? ~tri_q : tri_q;
      default: wave_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    f_act_d  = f_act_q;
    w_act_d  = w_act_q;
    d_act_d  = d_act_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    sync_d   = sync_q;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d  = '0;
        sample_d = '0;
        valid_d  = 1'b0;
        sync_d   = 1'b0;
        load     = 1'b1;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_d  = S_IDLE;
          phase_d  = '0;
          sample_d = '0;
          valid_d  = 1'b0;
          sync_d   = 1'b0;
        end else begin
          phase_d  = sum[ACC_W-1:0];
          sample_d = wave_val;
          valid_d  = 1'b1;
          sync_d   = sum[ACC_W];
          // a stalled accumulator never wraps, so it must accept new settings directly
          load     = sum[ACC_W] || (f_act_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      f_act_d = frequency;
      w_act_d = wave;
      d_act_d = duty_cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      f_act_q  <= '0;
      w_act_q  <= '0;
      d_act_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      f_act_q  <= f_act_d;
      w_act_q  <= w_act_d;
      d_act_q  <= d_act_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign sync         = sync_q;

endmodule

// File: tb/tb_nco_core.sv
// Bench for nco_core: vector table, hand-written corner sequences and a
// randomized run against an arithmetic reference model.
module tb_nco_core;

  localparam logic [63:0] F60 = 64'h1000_0000_0000_0000;
  localparam logic [63:0] F59 = 64'h0800_0000_0000_0000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  wave;
  logic [63:0] frequency;
  logic [15:0] duty_cycle;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sync;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  nco_core #(.ACC_W(64), .OUT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .wave         (wave),
    .frequency    (frequency),
    .duty_cycle   (duty_cycle),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sync         (sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst_n;
    bit          en;
    bit [1:0]    w;
    logic [63:0] f;
    logic [15:0] d;
    logic [15:0] exp_s;
    bit          exp_v;
    bit          exp_sy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the NCO described as whole-number arithmetic on a 64-bit phase.
  bit              m_run;
  longint unsigned m_ph, m_fa;
  bit [1:0]        m_wa;
  int unsigned     m_da;
  int unsigned     m_s;
  bit              m_v, m_sy;

  function automatic int unsigned shape(int unsigned ph16, bit [1:0] w, int unsigned duty);
    case (w)
      2'd0:    return (ph16 < duty) ? 32'hFFFF : 32'h0;
      2'd1:    return ph16;
      2'd2:    return (ph16 < 32'h8000) ? 2 * ph16 : 32'hFFFF - 2 * (ph16 - 32'h8000);
      default: return 0;
    endcase
  endfunction

  task automatic model_load();
    m_fa = frequency;
    m_wa = wave;
    m_da = duty_cycle;
  endtask

  task automatic model_edge();
    longint unsigned nxt;
    bit              wrapped;
    if (!reset) begin
      m_run = 0; m_ph = 0; m_fa = 0; m_wa = 0; m_da = 0;
      m_s = 0; m_v = 0; m_sy = 0;
    end else if (!m_run) begin
      m_ph = 0; m_s = 0; m_v = 0; m_sy = 0;
      model_load();
      if (enable) m_run = 1;
    end else if (!enable) begin
      m_run = 0; m_ph = 0; m_s = 0; m_v = 0; m_sy = 0;
    end else begin
      m_s     = shape(int'(m_ph / 64'h0001_0000_0000_0000), m_wa, m_da);
      m_v     = 1;
      nxt     = m_ph + m_fa;
      wrapped = (nxt < m_ph);
      m_sy    = wrapped;
      if (wrapped || m_fa == 0) model_load();
      m_ph    = nxt;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit en, bit [1:0] w, logic [63:0] f, logic [15:0] d);
    reset      = r;
    enable     = en;
    wave       = w;
    frequency  = f;
    duty_cycle = d;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic check_out(string name, logic [15:0] es, bit ev, bit esy);
    check({name, ".sample"}, 64'(sample), 64'(es));
    check({name, ".valid"}, 64'(sample_valid), 64'(ev));
    check({name, ".sync"}, 64'(sync), 64'(esy));
  endtask

  task automatic add(bit r, bit en, bit [1:0] w, logic [63:0] f, logic [15:0] d,
                     logic [15:0] es, bit ev, bit esy);
    vec_t v;
    v.rst_n = r; v.en = en; v.w = w; v.f = f; v.d = d;
    v.exp_s = es; v.exp_v = ev; v.exp_sy = esy;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] tri_exp(int i);
    return (i < 8) ? 16'(i * 16'h2000) : 16'(16'hFFFF - (i - 8) * 16'h2000);
  endfunction

  initial begin
    // reset held with enable high, then sawtooth
    add(0, 1, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    add(0, 1, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    add(1, 1, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 32; i++)
      add(1, 1, 2'd1, F60, 16'h0, 16'((i % 16) << 12), 1, (i % 16) == 15);
    // reset mid-run, then restart
    add(0, 1, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    add(1, 1, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 2'd1, F60, 16'h0, 16'(i << 12), 1, 0);
    add(1, 0, 2'd1, F60, 16'h0, 16'h0, 0, 0);
    // square, 50% duty
    add(1, 1, 2'd0, F60, 16'h8000, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++)
      add(1, 1, 2'd0, F60, 16'h8000, (i < 8) ? 16'hFFFF : 16'h0, 1, i == 15);
    add(1, 0, 2'd0, F60, 16'h8000, 16'h0, 0, 0);
    // square, zero duty
    add(1, 1, 2'd0, F60, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 2'd0, F60, 16'h0, 16'h0, 1, i == 15);
    add(1, 0, 2'd0, F60, 16'h0, 16'h0, 0, 0);
    // square, full duty: high everywhere these phases land
    add(1, 1, 2'd0, F60, 16'hFFFF, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 2'd0, F60, 16'hFFFF, 16'hFFFF, 1, i == 15);
    add(1, 0, 2'd0, F60, 16'hFFFF, 16'h0, 0, 0);
    // triangle
    add(1, 1, 2'd2, F60, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 2'd2, F60, 16'h0, tri_exp(i), 1, i == 15);
    add(1, 0, 2'd2, F60, 16'h0, 16'h0, 0, 0);
    // reserved waveform
    add(1, 1, 2'd3, F60, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 2'd3, F60, 16'h0, 16'h0, 1, i == 15);
    add(1, 0, 2'd3, F60, 16'h0, 16'h0, 0, 0);

    drive(0, 0, 2'd0, 64'h0, 16'h0);
    #2;
    foreach (tbl[k]) begin
      drive(tbl[k].rst_n, tbl[k].en, tbl[k].w, tbl[k].f, tbl[k].d);
      step();
      check_out($sformatf("tbl[%0d]", k), tbl[k].exp_s, tbl[k].exp_v, tbl[k].exp_sy);
    end

    // deferred update: new settings written mid-period take effect after the wrap
    drive(1, 1, 2'd1, F60, 16'h8000);
    step();
    check_out("defer.load", 16'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("defer.pre", 16'(i << 12), 1, 0);
    end
    frequency = F59;
    wave      = 2'd0;
    for (int i = 5; i < 16; i++) begin
      step();
      check_out("defer.old", 16'(i << 12), 1, i == 15);
    end
    for (int j = 0; j < 32; j++) begin
      step();
      check_out("defer.new", (j < 16) ? 16'hFFFF : 16'h0, 1, j == 31);
    end
    enable = 0;
    step();
    check_out("defer.stop", 16'h0, 0, 0);

    // stall at zero frequency, then accept a new step, then stop mid-period
    drive(1, 1, 2'd1, 64'h0, 16'h0);
    step();
    check_out("stall.load", 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("stall.hold", 16'h0, 1, 0);
    end
    frequency = F60;
    step();
    check_out("stall.accept", 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("stall.ramp", 16'(i << 12), 1, 0);
    end
    enable = 0;
    step();
    check_out("stall.stop", 16'h0, 0, 0);

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       frequency = 64'h0;
          1:       frequency = {$urandom, $urandom};
          default: frequency = 64'h1 << $urandom_range(55, 63);
        endcase
        wave       = 2'($urandom_range(0, 3));
        duty_cycle = 16'($urandom);
      end
      step();
      check("rand.sample", 64'(sample), 64'(m_s));
      check("rand.valid", 64'(sample_valid), 64'(m_v));
      check("rand.sync", 64'(sync), 64'(m_sy));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/nco_core.md
NCO_CORE -- requirements
Module: nco_core

Interface
REQ-001 SHALL have parameter ACC_W, default 64, meaning phase-accumulator and tuning-word width.
REQ-002 SHALL have parameter OUT_W, default 16, meaning sample width; phase index p = P[ACC_W-1:ACC_W-OUT_W].
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: run request from the I2C control slave.
REQ-006 SHALL have port wave, input, 2 bits: waveform select (00 square, 01 sawtooth, 10 triangle, 11 reserved).
REQ-007 SHALL have port frequency, input, ACC_W bits: phase step per clock.
REQ-008 SHALL have port duty_cycle, input, OUT_W bits: square-wave high threshold.
REQ-009 SHALL have port sample, output, OUT_W bits: registered unsigned waveform sample.
REQ-010 SHALL have port sample_valid, output, 1 bit: sample is meaningful.
REQ-011 SHALL have port sync, output, 1 bit: one-cycle pulse marking accumulator wrap.

Function
REQ-012 SHALL implement two states, IDLE and RUN.
REQ-013 SHALL, in IDLE, hold P=0, sample=0, sample_valid=0, sync=0, and copy frequency/wave/duty_cycle into the active registers F_act/W_act/D_act every cycle.
REQ-014 SHALL, at the edge where IDLE sees enable=1, go to RUN, set P=0, load the active registers, and keep sample_valid=0.
REQ-015 SHALL, on every RUN edge, set {carry,P} <= P + F_act with the sum taken modulo 2^ACC_W; sample <= f(p of the pre-add P); sample_valid <= 1; sync <= carry.
REQ-016 SHALL, at a RUN edge with carry=1, load F_act/W_act/D_act from the inputs, so that updates are glitch-free at period boundaries.
REQ-017 SHALL, while in RUN with F_act=0, load the active registers every cycle, so a stalled NCO accepts a new frequency.
REQ-018 SHALL ignore input changes in RUN outside REQ-016 and REQ-017.
REQ-019 SHALL use the square function f(p) = (p < D_act) ? all-ones : 0; D_act=0 gives constant 0; D_act=all-ones gives low only at p=all-ones.
REQ-020 SHALL use the sawtooth function f(p) = p.
REQ-021 SHALL use the triangle function, with q = {p[OUT_W-2:0],1'b0}: f(p) = q when p[MSB]=0, otherwise ~q.
REQ-022 SHALL output sample=0 with sample_valid=1 when W_act=11.
REQ-023 SHALL, at the edge where RUN sees enable=0, go to IDLE with all outputs and P cleared.
REQ-024 SHALL produce its first valid sample (f(0)) on the second edge after enable is first sampled high.
REQ-025 SHALL treat sync=1 as meaning P has just wrapped; the next sample is the first sample of the new period.

Reset
REQ-026 SHALL, when reset=0 at an edge, force IDLE, P=0, F_act=0, W_act=0, D_act=0, sample=0, sample_valid=0, and sync=0, regardless of state or enable.
REQ-027 SHALL give reset priority over enable; reset asserted mid-run SHALL zero all outputs at that edge.
REQ-028 SHALL, after reset releases with enable=1, follow the REQ-014 and REQ-024 sequence.

Verification
REQ-029 SHALL cover reset: hold reset=0 for 2 cycles with enable=1 -> sample=0, sample_valid=0, sync=0, P=0.
REQ-030 SHALL cover sawtooth: wave=01, frequency=64'h1000_0000_0000_0000, enable=1 -> samples 0x0000, 0x1000, ..., 0xF000 repeating; sync pulses every 16 cycles, high alongside sample 0xF000.
REQ-031 SHALL cover square: wave=00, duty_cycle=0x8000, same frequency -> 8 samples of 0xFFFF then 8 of 0x0000; also duty=0x0000 -> all 0x0000.
REQ-032 SHALL cover triangle: wave=10, same frequency -> 0x0000, 0x2000, ..., 0xE000, then 0xFFFF, 0xDFFF, ..., 0x1FFF.
REQ-033 SHALL cover deferred update: sawtooth running at step 2^60; at cycle 5 of a period write frequency=2^59 and wave=00 -> step stays 0x1000 until the sync edge, then step 0x0800 and square output.
REQ-034 SHALL cover the stall and stop cases: run with frequency=0 -> sample constant 0x0000; write 2^60 -> increments start next cycle; drop enable mid-period -> sample=0 and sample_valid=0 after one edge.
